writeback_stage: RTL

- Registered, parametrised writeback stage of the pipeline. Sits between the memory stage and the register file.
- Selects ALU result or load data and sizes/extends loads (byte/half/word). Waits for variable-latency memory responses.
- Supports flush and counts committed instructions.
- Drives the register-file write port and the forwarding path from one registered output set.

---
 rtl/writeback_stage_if.sv | 38 +++
 rtl/writeback_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// Writeback stage bundle: upstream instruction/memory-response inputs and register-file/forwarding outputs.
// The stage takes the slave modport; whoever feeds the pipeline takes master.
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 13,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] alu_res;
    logic              mem_read;
    logic [1:0]        mem_size;
    logic              mem_signed;
    logic [REG_AW-1:0] write_reg_in;
    logic              write_en_in;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              flush;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] write_data_out;
    logic [REG_AW-1:0] write_reg_out;
    logic              write_en_out;
    logic [CNT_W-1:0]  commit_count;

    modport master (
        output in_valid, pc_in, alu_res, mem_read, mem_size, mem_signed,
               write_reg_in, write_en_in, mem_rdata, mem_rvalid, flush,
        input  in_ready, pc_out, write_data_out, write_reg_out, write_en_out, commit_count
    );

    modport slave (
        input  in_valid, pc_in, alu_res, mem_read, mem_size, mem_signed,
               write_reg_in, write_en_in, mem_rdata, mem_rvalid, flush,
        output in_ready, pc_out, write_data_out, write_reg_out, write_en_out, commit_count
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: picks ALU result or sized/extended load data; 1-cycle latency, stalls on outstanding loads.
// Backpressure: in_ready drops while waiting for (or draining) a memory response.
module writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 13,
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input  logic clk,
    input  logic rst_n,
    writeback_stage_if.slave wb
);
    localparam int L = $clog2(DATA_W / 8);
    localparam logic [L-1:0] HMASK = ~L'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [L-1:0]      off_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [REG_AW-1:0] reg_q;
    logic              wen_q;

    logic [PC_W-1:0]   pc_out_q;
    logic [DATA_W-1:0] wdat_q;
    logic [REG_AW-1:0] wreg_q;
    logic              wen_out_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              accept;
    logic [L-1:0]      ld_off_d;
    logic [1:0]        ld_size_d;
    logic              ld_signed_d;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_dat_d;

    logic              commit_d;
    logic [PC_W-1:0]   commit_pc_d;
    logic [DATA_W-1:0] commit_dat_d;
    logic [REG_AW-1:0] commit_reg_d;
    logic              commit_wen_d;

    assign wb.in_ready       = (state_q == IDLE);
    assign accept            = wb.in_valid & wb.in_ready & ~wb.flush;
    assign wb.pc_out         = pc_out_q;
    assign wb.write_data_out = wdat_q;
    assign wb.write_reg_out  = wreg_q;
    assign wb.write_en_out   = wen_out_q;
    assign wb.commit_count   = cnt_q;

    // Load attributes come straight from the inputs on a zero-latency hit, else from the captured copy.
    always_comb begin
        ld_off_d    = (state_q == IDLE) ? wb.alu_res[L-1:0] : off_q;
        ld_size_d   = (state_q == IDLE) ? wb.mem_size       : size_q;
        ld_signed_d = (state_q == IDLE) ? wb.mem_signed     : signed_q;
        ld_byte     = 8'(wb.mem_rdata >> {ld_off_d, 3'b000});
        ld_half     = 16'(wb.mem_rdata >> {ld_off_d & HMASK, 3'b000});
        ld_dat_d    = wb.mem_rdata;
        case (ld_size_d)
            2'b00:   ld_dat_d = ld_signed_d ? DATA_W'($signed(ld_byte)) : DATA_W'(ld_byte);
            2'b01:   ld_dat_d = ld_signed_d ? DATA_W'($signed(ld_half)) : DATA_W'(ld_half);
            default: ld_dat_d = wb.mem_rdata;
        endcase
    end

    always_comb begin
        commit_d     = 1'b0;
        commit_pc_d  = pc_q;
        commit_dat_d = ld_dat_d;
        commit_reg_d = reg_q;
        commit_wen_d = wen_q;
        case (state_q)
            IDLE: begin
                if (accept && (!wb.mem_read || wb.mem_rvalid)) begin
                    commit_d     = 1'b1;
                    commit_pc_d  = wb.pc_in;
                    commit_dat_d = wb.mem_read ? ld_dat_d : wb.alu_res;
                    commit_reg_d = wb.write_reg_in;
                    commit_wen_d = wb.write_en_in;
                end
            end
            WAIT_MEM: commit_d = wb.mem_rvalid & ~wb.flush;
            default:  commit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            off_q     <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            reg_q     <= '0;
            wen_q     <= 1'b0;
            pc_out_q  <= '0;
            wdat_q    <= '0;
            wreg_q    <= '0;
            wen_out_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wen_out_q <= 1'b0;
            if (commit_d) begin
                pc_out_q  <= commit_pc_d;
                wdat_q    <= commit_dat_d;
                wreg_q    <= commit_reg_d;
                wen_out_q <= commit_wen_d & ~((ZERO_REG != 0) && (commit_reg_d == '0));
                cnt_q     <= cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept && wb.mem_read && !wb.mem_rvalid) begin
                        pc_q     <= wb.pc_in;
                        off_q    <= wb.alu_res[L-1:0];
                        size_q   <= wb.mem_size;
                        signed_q <= wb.mem_signed;
                        reg_q    <= wb.write_reg_in;
                        wen_q    <= wb.write_en_in;
                        state_q  <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    // A flushed load whose response is still outstanding must swallow it in DRAIN.
                    if (wb.flush)           state_q <= wb.mem_rvalid ? IDLE : DRAIN;
                    else if (wb.mem_rvalid) state_q <= IDLE;
                end
                DRAIN: begin
                    if (wb.mem_rvalid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
